// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   RV32 pipeline EX stage. Selects forwarded operands, runs the ALU,
//   resolves branches/jumps, runs an iterative shift-add multiplier, and
//   holds the EX/MEM pipeline register.
//
// Parameters
//   XLEN   : datapath width
//   MUL_EN : 1 = iterative MUL supported, 0 = MUL returns 0 in one cycle
//
// Ports
//   clk, rst                 : clock (rising), synchronous active-low reset
//   ForwardAE/ForwardBE      : operand selects (00 RD, 01 ResultW, 10 ALUResult_M)
//   RD1_E/RD2_E/Imm_Ext_E    : register operands and immediate
//   PC_E/PCPlus4_E/Rd_E      : instruction PC, PC+4, destination register
//   ALUControl_E/ALUSrc_E    : ALU op and SrcB immediate select
//   BranchCond_E, Branch_E, Jump_E, Jalr_E : control-flow decode
//   RegWrite_E/MemWrite_E/ResultSrc_E      : controls forwarded to MEM
//   flush_E                  : turn the current EX instruction into a bubble
//   ResultW                  : writeback forwarding source
//   *_M                      : EX/MEM pipeline register
//   PCSrc_E/PCTarget_E       : fetch redirect (combinational)
//   busy_E                   : stall request while MUL iterates (combinational)
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [XLEN-1:0] PCPlus4_E,
    input  logic [4:0]      Rd_E,
    input  logic [3:0]      ALUControl_E,
    input  logic            ALUSrc_E,
    input  logic [2:0]      BranchCond_E,
    input  logic            Branch_E,
    input  logic            Jump_E,
    input  logic            Jalr_E,
    input  logic            RegWrite_E,
    input  logic            MemWrite_E,
    input  logic [1:0]      ResultSrc_E,
    input  logic            flush_E,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUResult_M,
    output logic [XLEN-1:0] WriteData_M,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4_M,
    output logic            RegWrite_M,
    output logic            MemWrite_M,
    output logic [1:0]      ResultSrc_M,
    output logic            PCSrc_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic            busy_E
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc4;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } exmem_t;

    mul_state_t      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mul_a, mul_b, acc;

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, jalr_sum;
    logic [4:0]      shamt;
    logic            taken, mul_req;
    exmem_t          exm, exm_d;

    // ---------------- operand selection ----------------
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResult_M;
            default: src_a = RD1_E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResult_M;
            default: fwd_b = RD2_E;
        endcase
        src_b = ALUSrc_E ? Imm_Ext_E : fwd_b;
        shamt = src_b[4:0];
    end

    // ---------------- ALU ----------------
    always_comb begin
        alu_res = '0;
        case (ALUControl_E)
            4'd0:  alu_res = src_a + src_b;
            4'd1:  alu_res = src_a - src_b;
            4'd2:  alu_res = src_a & src_b;
            4'd3:  alu_res = src_a | src_b;
            4'd4:  alu_res = src_a ^ src_b;
            4'd5:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd6:  alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'd7:  alu_res = src_a << shamt;
            4'd8:  alu_res = src_a >> shamt;
            4'd9:  alu_res = XLEN'($signed(src_a) >>> shamt);
            // Only DONE ever reaches the EX/MEM register; other MUL cycles are bubbles.
            4'd10: alu_res = (state == DONE) ? acc : '0;
            default: alu_res = '0;
        endcase
    end

    // ---------------- branch / jump resolution ----------------
    always_comb begin
        case (BranchCond_E)
            3'b000:  taken = (src_a == fwd_b);
            3'b001:  taken = (src_a != fwd_b);
            3'b100:  taken = ($signed(src_a) <  $signed(fwd_b));
            3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  taken = (src_a <  fwd_b);
            3'b111:  taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
        jalr_sum   = src_a + Imm_Ext_E;
        PCTarget_E = Jalr_E ? {jalr_sum[XLEN-1:1], 1'b0} : (PC_E + Imm_Ext_E);
        PCSrc_E    = ~flush_E & (Jump_E | Jalr_E | (Branch_E & taken));
    end

    // Stall is gated by rst so a reset cycle never requests a hold.
    assign mul_req = rst & MUL_EN & (ALUControl_E == 4'd10) & ~flush_E & (state == IDLE);
    assign busy_E  = rst & (mul_req | (state == BUSY));

    // ---------------- iterative multiplier ----------------
    // Operands are latched on entry: the forwarded WB value moves on while
    // the upstream stages are held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
        end else if (flush_E) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (mul_req) begin
                    state <= BUSY;
                    mul_a <= src_a;
                    mul_b <= src_b;
                    acc   <= '0;
                    cnt   <= '0;
                end
                BUSY: begin
                    acc   <= acc + (mul_b[0] ? mul_a : '0);
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- EX/MEM register ----------------
    always_comb begin
        exm_d.alu        = alu_res;
        exm_d.wdata      = fwd_b;
        exm_d.rd         = Rd_E;
        exm_d.pc4        = PCPlus4_E;
        exm_d.reg_write  = RegWrite_E;
        exm_d.mem_write  = MemWrite_E;
        exm_d.result_src = ResultSrc_E;
    end

    // Bubble clears only the side-effecting fields; data fields hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exm <= '0;
        end else if (flush_E || busy_E) begin
            exm.reg_write <= 1'b0;
            exm.mem_write <= 1'b0;
            exm.rd        <= '0;
        end else begin
            exm <= exm_d;
        end
    end

    assign ALUResult_M = exm.alu;
    assign WriteData_M = exm.wdata;
    assign RD_M        = exm.rd;
    assign PCPlus4_M   = exm.pc4;
    assign RegWrite_M  = exm.reg_write;
    assign MemWrite_M  = exm.mem_write;
    assign ResultSrc_M = exm.result_src;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//   Randomized and directed stimulus for execute_stage, checked against a
//   behavioural model: ALU results from plain arithmetic, MUL as a*b with a
//   fixed stall length, and a shadow copy of the EX/MEM register.
// ---------------------------------------------------------------------------
module tb_execute_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E, ResultW;
    logic [4:0]      Rd_E;
    logic [3:0]      ALUControl_E;
    logic            ALUSrc_E;
    logic [2:0]      BranchCond_E;
    logic            Branch_E, Jump_E, Jalr_E, RegWrite_E, MemWrite_E, flush_E;
    logic [1:0]      ResultSrc_E;
    logic [XLEN-1:0] ALUResult_M, WriteData_M, PCPlus4_M, PCTarget_E;
    logic [4:0]      RD_M;
    logic            RegWrite_M, MemWrite_M, PCSrc_E, busy_E;
    logic [1:0]      ResultSrc_M;

    execute_stage #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E),
        .PCPlus4_E(PCPlus4_E), .Rd_E(Rd_E), .ALUControl_E(ALUControl_E),
        .ALUSrc_E(ALUSrc_E), .BranchCond_E(BranchCond_E), .Branch_E(Branch_E),
        .Jump_E(Jump_E), .Jalr_E(Jalr_E), .RegWrite_E(RegWrite_E),
        .MemWrite_E(MemWrite_E), .ResultSrc_E(ResultSrc_E), .flush_E(flush_E),
        .ResultW(ResultW), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
        .RD_M(RD_M), .PCPlus4_M(PCPlus4_M), .RegWrite_M(RegWrite_M),
        .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M), .PCSrc_E(PCSrc_E),
        .PCTarget_E(PCTarget_E), .busy_E(busy_E)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;
    int          mul_cnt;   // 0 = no MUL in flight, else cycles spent so far
    logic [31:0] mul_prod;
    logic        seen_busy, seen_pcsrc;
    logic [31:0] seen_tgt;

    function automatic logic [31:0] sel(input logic [1:0] s, input logic [31:0] rd);
        case (s)
            2'b01:   return ResultW;
            2'b10:   return m_alu;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] p);
        int sh;
        logic signed [31:0] sa, sb;
        sh = int'(b[4:0]);
        sa = a;
        sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return 32'(sa >>> sh);
            4'd10: return p;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: inputs already applied (at negedge). Check combinational
    // outputs, advance the model across posedge, check registered outputs.
    task automatic cycle();
        logic [31:0] a, fb, b, res, tgt;
        logic        exp_busy, exp_pcsrc, is_mul;
        #1;
        seen_busy  = busy_E;
        seen_pcsrc = PCSrc_E;
        seen_tgt   = PCTarget_E;
        a  = sel(ForwardAE, RD1_E);
        fb = sel(ForwardBE, RD2_E);
        b  = ALUSrc_E ? Imm_Ext_E : fb;
        is_mul = (ALUControl_E == 4'd10);
        if (!rst) begin
            exp_busy = 1'b0;
            check("busy_rst", {31'd0, busy_E}, 32'd0);
        end else begin
            if (mul_cnt == 0) exp_busy = is_mul && !flush_E;
            else              exp_busy = (mul_cnt <= XLEN);
            exp_pcsrc = !flush_E && (Jump_E || Jalr_E || (Branch_E && ref_taken(BranchCond_E, a, fb)));
            tgt = Jalr_E ? ((a + Imm_Ext_E) & ~32'd1) : (PC_E + Imm_Ext_E);
            check("busy", {31'd0, busy_E}, {31'd0, exp_busy});
            check("pcsrc", {31'd0, PCSrc_E}, {31'd0, exp_pcsrc});
            check("pctarget", PCTarget_E, tgt);
        end
        res = ref_alu(ALUControl_E, a, b, mul_prod);
        @(posedge clk);
        if (!rst) begin
            {m_alu, m_wd, m_pc4, m_rd, m_rw, m_mw, m_rs} = '0;
            mul_cnt = 0;
        end else begin
            if (flush_E || exp_busy) begin
                m_rw = 1'b0; m_mw = 1'b0; m_rd = 5'd0;
            end else begin
                m_alu = res; m_wd = fb; m_rd = Rd_E; m_pc4 = PCPlus4_E;
                m_rw = RegWrite_E; m_mw = MemWrite_E; m_rs = ResultSrc_E;
            end
            if (flush_E)                 mul_cnt = 0;
            else if (mul_cnt == 0) begin
                if (exp_busy) begin mul_cnt = 1; mul_prod = a * b; end
            end
            else if (mul_cnt == XLEN+1)  mul_cnt = 0;
            else                         mul_cnt++;
        end
        @(negedge clk);
        check("alu_m", ALUResult_M, m_alu);
        check("wdata_m", WriteData_M, m_wd);
        check("rd_m", {27'd0, RD_M}, {27'd0, m_rd});
        check("pc4_m", PCPlus4_M, m_pc4);
        check("regwrite_m", {31'd0, RegWrite_M}, {31'd0, m_rw});
        check("memwrite_m", {31'd0, MemWrite_M}, {31'd0, m_mw});
        check("resultsrc_m", {30'd0, ResultSrc_M}, {30'd0, m_rs});
    endtask

    task automatic clr();
        ForwardAE = 0; ForwardBE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
        PC_E = 0; PCPlus4_E = 0; Rd_E = 0; ALUControl_E = 0; ALUSrc_E = 0;
        BranchCond_E = 0; Branch_E = 0; Jump_E = 0; Jalr_E = 0;
        RegWrite_E = 0; MemWrite_E = 0; ResultSrc_E = 0; flush_E = 0; ResultW = 0;
    endtask

    task automatic rand_instr();
        ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
        RD1_E = $urandom; RD2_E = $urandom; ResultW = $urandom;
        Imm_Ext_E = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        PC_E = $urandom; PCPlus4_E = PC_E + 32'd4; Rd_E = 5'($urandom);
        ALUControl_E = 4'($urandom_range(0, 15));
        if (ALUControl_E == 4'd10) ALUControl_E = 4'd0;
        ALUSrc_E = 1'($urandom); BranchCond_E = 3'($urandom);
        Branch_E = 1'($urandom); Jump_E = ($urandom_range(0, 5) == 0);
        Jalr_E = ($urandom_range(0, 5) == 0);
        RegWrite_E = 1'($urandom); MemWrite_E = 1'($urandom);
        ResultSrc_E = 2'($urandom); flush_E = ($urandom_range(0, 7) == 0);
    endtask

    int busy_cnt, wr_cnt;
    logic [31:0] wr_val;

    initial begin
        mul_cnt = 0; mul_prod = 0;
        {m_alu, m_wd, m_pc4, m_rd, m_rw, m_mw, m_rs} = '0;
        rst = 1'b0;
        clr();
        @(negedge clk);

        // Reset with random inputs (including a MUL request)
        for (int i = 0; i < 2; i++) begin
            rand_instr();
            if (i == 1) ALUControl_E = 4'd10;
            cycle();
        end
        check("rst_alu", ALUResult_M, 32'd0);
        check("rst_regwrite", {31'd0, RegWrite_M}, 32'd0);
        rst = 1'b1;

        // Forwarding
        clr(); RD1_E = 100; RegWrite_E = 1; Rd_E = 1; cycle();
        RD1_E = 5; RD2_E = 3; ResultW = 7; ForwardAE = 2'b10; ForwardBE = 2'b01; Rd_E = 2;
        cycle();
        check("fwd_add", ALUResult_M, 32'd107);
        check("fwd_wdata", WriteData_M, 32'd7);
        ForwardAE = 2'b11; cycle();
        check("fwd_sel11", ALUResult_M, 32'd12);

        // Branch: signed vs unsigned compare
        clr(); RD1_E = 32'hFFFF_FFFF; RD2_E = 1; PC_E = 32'h100; Imm_Ext_E = 32'h20;
        Branch_E = 1; BranchCond_E = 3'b100; cycle();
        check("blt_pcsrc", {31'd0, seen_pcsrc}, 32'd1);
        check("blt_target", seen_tgt, 32'h120);
        BranchCond_E = 3'b110; cycle();
        check("bltu_pcsrc", {31'd0, seen_pcsrc}, 32'd0);

        // JALR
        clr(); RD1_E = 32'h1001; Imm_Ext_E = 32'h4; Jalr_E = 1; cycle();
        check("jalr_target", seen_tgt, 32'h1004);
        check("jalr_pcsrc", {31'd0, seen_pcsrc}, 32'd1);

        // MUL with a moving WB forward source during the stall
        clr(); ALUControl_E = 4'd10; ForwardAE = 2'b01; ResultW = 32'hFFFF_FFFF;
        RD2_E = 3; RegWrite_E = 1; Rd_E = 5;
        busy_cnt = 0; wr_cnt = 0; wr_val = 0;
        for (int i = 0; i < XLEN + 2; i++) begin
            cycle();
            if (seen_busy) busy_cnt++;
            if (RegWrite_M) begin wr_cnt++; wr_val = ALUResult_M; end
            ResultW = $urandom;
        end
        clr(); cycle();
        if (RegWrite_M) wr_cnt++;
        check("mul_busy_cycles", 32'(busy_cnt), 32'd33);
        check("mul_write_once", 32'(wr_cnt), 32'd1);
        check("mul_result", wr_val, 32'hFFFF_FFFD);

        // Abort by flush at BUSY cycle 10, then ADD 2+2
        clr(); ALUControl_E = 4'd10; RD1_E = 7; RD2_E = 9; RegWrite_E = 1; Rd_E = 3;
        wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (RegWrite_M) wr_cnt++;
        end
        flush_E = 1; cycle();
        if (RegWrite_M) wr_cnt++;
        clr(); RD1_E = 2; RD2_E = 2; RegWrite_E = 1; Rd_E = 4; cycle();
        check("abort_busy", {31'd0, seen_busy}, 32'd0);
        check("abort_nowrite", 32'(wr_cnt), 32'd0);
        check("abort_add", ALUResult_M, 32'd4);

        // Reset in the middle of a MUL
        clr(); ALUControl_E = 4'd10; RD1_E = 11; RD2_E = 13; RegWrite_E = 1; Rd_E = 6;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b0; cycle();
        check("rstmul_alu", ALUResult_M, 32'd0);
        check("rstmul_rd", {27'd0, RD_M}, 32'd0);
        rst = 1'b1; clr(); cycle();
        check("rstmul_busy", {31'd0, seen_busy}, 32'd0);

        // Randomized traffic; MUL is held until it completes or is flushed
        for (int n = 0; n < 300; n++) begin
            rand_instr();
            if ($urandom_range(0, 9) == 0) ALUControl_E = 4'd10;
            cycle();
            if (ALUControl_E == 4'd10) begin
                for (int k = 0; k < 40 && mul_cnt != 0; k++) begin
                    ResultW = $urandom;
                    flush_E = ($urandom_range(0, 29) == 0);
                    cycle();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
